// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// When CLA_PIPE_ADDER_OVF_EN is defined, the bundle also carries the signed-overflow flag ovf.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, in0, in1, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, in0, in1, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined adder built from 4-bit carry-lookahead groups, with the groups split across STAGES slices.
// Defining CLA_PIPE_ADDER_OVF_EN adds a pipelined signed-overflow output (ovf).
module cla_pipe_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned NumGroups = WIDTH / 4;
    localparam int unsigned Base      = NumGroups / STAGES;
    localparam int unsigned Rem       = NumGroups % STAGES;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
`ifdef CLA_PIPE_ADDER_OVF_EN
        logic             c_msb;
`endif
    } stage_t;

    // The first Rem slices hold Base+1 groups each; the remaining slices hold Base groups each.
    function automatic int unsigned grp_stage(int unsigned g);
        if (g < Rem * (Base + 1)) return g / (Base + 1);
        return Rem + (g - Rem * (Base + 1)) / Base;
    endfunction

    // Result layout: {group carry-out, carry into bit 3, sum[3:0]}.
    function automatic logic [5:0] cla4(logic [3:0] a, logic [3:0] b, logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        logic       gg;
        logic       pp;
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp   = &p;
        return {gg | (pp & ci), c[3], p ^ c};
    endfunction

    stage_t              in_stage;
    stage_t              src [STAGES];
    stage_t [STAGES-1:0] stg_d;
    stage_t [STAGES-1:0] stg_q;
    stage_t              last;
    logic                advance;

    always_comb begin
        in_stage   = '0;
        in_stage.v = bus.in_valid;
        in_stage.a = bus.in0;
        in_stage.b = bus.in1;
        in_stage.c = bus.cin;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_src
        if (s == 0) begin : g_first
            assign src[s] = in_stage;
        end else begin : g_next
            assign src[s] = stg_q[s-1];
        end
    end

    // Each stage resolves its own slice of groups, rippling the group carry upward.
    always_comb begin
        logic       carry;
        logic [5:0] grp;
        carry = 1'b0;
        grp   = '0;
        stg_d = '0;
        for (int s = 0; s < STAGES; s++) begin
            stg_d[s] = src[s];
            carry    = src[s].c;
            for (int g = 0; g < NumGroups; g++) begin
                if (grp_stage(g) == s) begin
                    grp                  = cla4(src[s].a[4*g +: 4], src[s].b[4*g +: 4], carry);
                    stg_d[s].s[4*g +: 4] = grp[3:0];
                    carry                = grp[5];
`ifdef CLA_PIPE_ADDER_OVF_EN
                    if (g == NumGroups - 1) stg_d[s].c_msb = grp[4];
`endif
                end
            end
            stg_d[s].c = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q <= '0;
        end else if (advance) begin
            stg_q <= stg_d;
        end
    end

    assign last          = stg_q[STAGES-1];
    assign advance       = !(last.v && !bus.out_ready);
    assign bus.in_ready  = advance;
    assign bus.out_valid = last.v;
    assign bus.sum       = last.s;
    assign bus.cout      = last.c;
`ifdef CLA_PIPE_ADDER_OVF_EN
    assign bus.ovf       = last.c_msb ^ last.c;
`endif

    // All operand bits have been consumed by the time they reach the output stage.
    logic unused_ops;
    assign unused_ops = ^{last.a, last.b};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard testbench for cla_pipe_adder (WIDTH=8, STAGES=2), checked against plain integer addition.
module tb_cla_pipe_adder;
    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
        int           stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   stall_cnt = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(
        .WIDTH (W),
        .STAGES(S)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in0       = a;
        bus.in1       = b;
        bus.cin       = c;
        bus.out_ready = ordy;
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: plain integer addition, overflow from operand/result signs.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            logic [W:0] full;
            exp_t       e;
            full  = {1'b0, bus.in0} + {1'b0, bus.in1} + {{W{1'b0}}, bus.cin};
            e.s   = full[W-1:0];
            e.c   = full[W];
            e.o   = (bus.in0[W-1] == bus.in1[W-1]) && (full[W-1] != bus.in0[W-1]);
            e.cyc = cyc_cnt;
            e.stl = stall_cnt;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got sum=%0h, expected no result", bus.sum);
            end else if (bus.out_ready) begin
                exp_t e;
                e = q.pop_front();
                check("sum", 64'(bus.sum), 64'(e.s));
                check("cout", 64'(bus.cout), 64'(e.c));
`ifdef CLA_PIPE_ADDER_OVF_EN
                check("ovf", 64'(bus.ovf), 64'(e.o));
`endif
                check("latency", 64'(cyc_cnt - e.cyc), 64'(int'(S) + stall_cnt - e.stl));
            end else begin
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_sum_hold", 64'({bus.cout, bus.sum}), 64'({q[0].c, q[0].s}));
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in0       = '0;
        bus.in1       = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        check("reset_cout", 64'(bus.cout), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Release reset with a transaction already presented.
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.cin      = 1'b1;

        drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        drive(1'b1, 8'h00, 8'hFF, 1'b1, 1'b1);
        drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
        drive(1'b1, 8'hAA, 8'h55, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 8'(i), 1'b0, 1'b1);
        repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Three-cycle output stall with inputs offered throughout.
        drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
        drive(1'b1, 8'h30, 8'h40, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 8'hEE, 8'hEE, 1'b1, 1'b0);
        drive(1'b1, 8'h70, 8'h80, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Reset with two transactions in flight.
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_reset_sum", 64'(bus.sum), 64'd0);
        check("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in0      = 8'h12;
        bus.in1      = 8'h34;
        bus.cin      = 1'b0;

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
